ball_physics_engine: RTL

- Parametrised successor to the existing game-top ball logic, pulled out into its own block.
- Owns ball position, velocity, bounce FSM, score and record.
- Sits between paddle control (input: paddle right edge X) and the sprite renderer and score display (outputs: ball X/Y, score, record).
- Playfield bounds, paddle geometry, speed caps and tick rate are all parameters.

---
 rtl/ball_pkg.sv | 35 +++
 rtl/tick_divider.sv | 27 ++
 rtl/ball_physics_engine.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared types and default geometry for the ball physics engine.
// Consumed by ball_physics_engine (optional speed-up feature: BALL_SPEEDUP_EN).
package ball_pkg;

  typedef enum logic [2:0] {
    BALL_ST_DOWN_L = 3'd0,
    BALL_ST_DOWN_R = 3'd1,
    BALL_ST_UP_L   = 3'd2,
    BALL_ST_UP_R   = 3'd3,
    BALL_ST_OVER   = 3'd4
  } ball_state_e;

  typedef enum logic [1:0] {
    ZONE_LEFT   = 2'd0,
    ZONE_CENTRE = 2'd1,
    ZONE_RIGHT  = 2'd2
  } zone_e;

  localparam int DEF_COORD_W    = 11;
  localparam int DEF_DELTA_W    = 7;
  localparam int DEF_SCORE_W    = 12;
  localparam int DEF_TICK_DIV   = 1048576;
  localparam int DEF_X_MIN      = 150;
  localparam int DEF_X_MAX      = 776;
  localparam int DEF_Y_MIN      = 55;
  localparam int DEF_Y_PAD      = 485;
  localparam int DEF_Y_LOSE     = 510;
  localparam int DEF_PADDLE_W   = 170;
  localparam int DEF_EDGE_W     = 30;
  localparam int DEF_X_START    = 464;
  localparam int DEF_Y_START    = 275;
  localparam int DEF_DELTA_INIT = 2;
  localparam int DEF_DELTA_MAX  = 50;

endpackage

// File: rtl/tick_divider.sv
// Movement tick generator: counts 0..TICK_DIV-1 and pulses tick on the wrap cycle.
module tick_divider #(
  parameter int TICK_DIV = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset || restart) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_physics_engine.sv
// Ball position/velocity, bounce FSM, score and record keeping for the game top.
// Optional: define BALL_SPEEDUP_EN to add +1 to dx/dy on every paddle hit.
module ball_physics_engine
  import ball_pkg::*;
#(
  parameter int COORD_W    = DEF_COORD_W,
  parameter int DELTA_W    = DEF_DELTA_W,
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int X_MIN      = DEF_X_MIN,
  parameter int X_MAX      = DEF_X_MAX,
  parameter int Y_MIN      = DEF_Y_MIN,
  parameter int Y_PAD      = DEF_Y_PAD,
  parameter int Y_LOSE     = DEF_Y_LOSE,
  parameter int PADDLE_W   = DEF_PADDLE_W,
  parameter int EDGE_W     = DEF_EDGE_W,
  parameter int X_START    = DEF_X_START,
  parameter int Y_START    = DEF_Y_START,
  parameter int DELTA_INIT = DEF_DELTA_INIT,
  parameter int DELTA_MAX  = DEF_DELTA_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic [COORD_W-1:0] paddle_x,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [DELTA_W-1:0] ball_dx,
  output logic [DELTA_W-1:0] ball_dy,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] record,
  output logic               hit,
  output logic               game_over
);

  // Two guard bits keep x+dx and paddle_x-PADDLE_W from wrapping.
  localparam int SW = COORD_W + 2;
  localparam int DW = DELTA_W + 2;

  localparam logic signed [SW-1:0] S_X_MIN  = SW'(X_MIN);
  localparam logic signed [SW-1:0] S_X_MAX  = SW'(X_MAX);
  localparam logic signed [SW-1:0] S_Y_MIN  = SW'(Y_MIN);
  localparam logic signed [SW-1:0] S_Y_PAD  = SW'(Y_PAD);
  localparam logic signed [SW-1:0] S_Y_LOSE = SW'(Y_LOSE);
  localparam logic signed [SW-1:0] S_PAD_W  = SW'(PADDLE_W);
  localparam logic signed [SW-1:0] S_EDGE_W = SW'(EDGE_W);
  localparam logic signed [DW-1:0] D_ONE    = DW'(1);
  localparam logic signed [DW-1:0] D_MAX    = DW'(DELTA_MAX);

  ball_state_e        state_q, state_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [DELTA_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [SCORE_W-1:0] score_q, score_d, record_q, record_d;
  logic               hit_q, hit_d;

  logic                 tick;
  logic                 going_up, going_right, up_n, right_n, over_n;
  logic signed [SW-1:0] xs, ys, dxs, dys, px, nx, ny, pad_l, pad_l_edge, pad_r_edge;
  logic signed [DW-1:0] dx_t, dy_t;
  zone_e                zone;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  function automatic logic [DELTA_W-1:0] clamp_delta(input logic signed [DW-1:0] v);
    if (v < D_ONE)      return DELTA_W'(1);
    else if (v > D_MAX) return DELTA_W'(DELTA_MAX);
    else                return v[DELTA_W-1:0];
  endfunction

  function automatic ball_state_e flight_state(input logic up, input logic right);
    case ({up, right})
      2'b00:   return BALL_ST_DOWN_L;
      2'b01:   return BALL_ST_DOWN_R;
      2'b10:   return BALL_ST_UP_L;
      default: return BALL_ST_UP_R;
    endcase
  endfunction

  assign going_up    = (state_q == BALL_ST_UP_L) || (state_q == BALL_ST_UP_R);
  assign going_right = (state_q == BALL_ST_DOWN_R) || (state_q == BALL_ST_UP_R);

  assign xs  = $signed({2'b00, ball_x_q});
  assign ys  = $signed({2'b00, ball_y_q});
  assign dxs = $signed({{(SW-DELTA_W){1'b0}}, dx_q});
  assign dys = $signed({{(SW-DELTA_W){1'b0}}, dy_q});
  assign px  = $signed({2'b00, paddle_x});

  assign nx         = going_right ? (xs + dxs) : (xs - dxs);
  assign ny         = going_up ? (ys - dys) : (ys + dys);
  assign pad_l      = px - S_PAD_W;
  assign pad_l_edge = pad_l + S_EDGE_W;
  assign pad_r_edge = px - S_EDGE_W;

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    score_d  = score_q;
    record_d = record_q;
    hit_d    = 1'b0;
    up_n     = going_up;
    right_n  = going_right;
    over_n   = 1'b0;
    zone     = ZONE_CENTRE;
    dx_t     = $signed({2'b00, dx_q});
    dy_t     = $signed({2'b00, dy_q});

    if (tick && state_q != BALL_ST_OVER) begin
      ball_y_d = ny[COORD_W-1:0];
      if (going_up) begin
        if (ny <= S_Y_MIN) begin
          ball_y_d = COORD_W'(Y_MIN);
          up_n     = 1'b0;
        end
      end else if (ny > S_Y_PAD) begin
        if (nx >= pad_l && nx <= px) begin
          ball_y_d = COORD_W'(Y_PAD);
          up_n     = 1'b1;
          hit_d    = 1'b1;
          score_d  = (score_q == '1) ? score_q : score_q + 1'b1;
`ifdef BALL_SPEEDUP_EN
          dx_t = dx_t + D_ONE;
          dy_t = dy_t + D_ONE;
`endif
          if (nx <= pad_l_edge)      zone = ZONE_LEFT;
          else if (nx >= pad_r_edge) zone = ZONE_RIGHT;
          case (zone)
            ZONE_LEFT: begin
              right_n = 1'b0;
              dx_t    = dx_t + D_ONE;
              dy_t    = dy_t - D_ONE;
            end
            ZONE_RIGHT: begin
              right_n = 1'b1;
              dx_t    = dx_t + D_ONE;
              dy_t    = dy_t + D_ONE;
            end
            default: ;
          endcase
          dx_d = clamp_delta(dx_t);
          dy_d = clamp_delta(dy_t);
        end else if (ny > S_Y_LOSE) begin
          ball_y_d = COORD_W'(Y_LOSE);
          over_n   = 1'b1;
        end
      end

      // Walls are resolved last so they override the paddle's horizontal choice.
      ball_x_d = nx[COORD_W-1:0];
      if (nx <= S_X_MIN) begin
        ball_x_d = COORD_W'(X_MIN);
        right_n  = 1'b1;
      end else if (nx >= S_X_MAX) begin
        ball_x_d = COORD_W'(X_MAX);
        right_n  = 1'b0;
      end

      if (over_n) begin
        state_d = BALL_ST_OVER;
        if (score_q > record_q) record_d = score_q;
      end else begin
        state_d = flight_state(up_n, right_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q  <= BALL_ST_DOWN_L;
      ball_x_q <= COORD_W'(X_START);
      ball_y_q <= COORD_W'(Y_START);
      dx_q     <= DELTA_W'(DELTA_INIT);
      dy_q     <= DELTA_W'(DELTA_INIT);
      score_q  <= '0;
      hit_q    <= 1'b0;
      if (reset) record_q <= '0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      score_q  <= score_d;
      hit_q    <= hit_d;
      record_q <= record_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign ball_dx   = dx_q;
  assign ball_dy   = dy_q;
  assign score     = score_q;
  assign record    = record_q;
  assign hit       = hit_q;
  assign game_over = (state_q == BALL_ST_OVER);

endmodule
